acc_core_param: RTL and testbench
=================================

Name: acc_core_param

Overview:
- Parametrised successor to the current 8-bit accumulator processor top level.
- Multi-cycle accumulator core: fetches instructions from an external instruction memory and executes load/ALU/store/jump operations against an external data memory.
- Generalises data width, data address width and PC width.
- Adds an immediate load, a conditional jump, a halt instruction that drives done, and a clean store handshake.

Parameters:
- DW, 8: data and accumulator width; also the width of each memory word.
- AW, 7: data memory address width; equals the instruction operand field width.
- PCW, 16: program counter width; must satisfy PCW <= 2*DW.
- IW, 11: instruction width; must equal 4+AW.

Ports:
- clk  input  1  rising-edge clock.
- start  input  1  synchronous active-high reset; also restarts the program from address 0.
- im_addr  output  PCW  instruction address; equals pc.
- im_data  input  IW  instruction word; combinational from im_addr, valid in the same cycle.
- dm_raddr  output  AW  registered data memory read address.
- dm_rdata  input  DW  data memory read data; valid the cycle after dm_raddr is registered.
- dm_we  output  1  registered write strobe, one-cycle pulse.
- dm_waddr  output  AW  registered write address.
- dm_wdata  output  DW  registered write data.
- acc_out  output  DW  accumulator value.
- done  output  1  high while halted.

Behaviour:
- Instruction decode: op = im_data[IW-1:IW-4]; a = im_data[AW-1:0].
- States: FETCH, EXEC, JMP_LO, HALT.
- Reset (start=1 at a rising edge, overriding all other activity):
  - pc=0, acc=0, state=FETCH, done=0.
  - dm_we=0, dm_raddr=0, dm_waddr=0, dm_wdata=0.
  - An in-flight instruction is abandoned; start asserted the same cycle as a STORE decode suppresses the write.
- FETCH decodes im_data and acts by opcode:
  - 0 POPCNT, 1 LOAD, 4 ADD, 5 AND, 7 XOR: dm_raddr<=a; pc<=pc+1; go to EXEC.
  - 2 STORE: dm_we<=1, dm_waddr<=a, dm_wdata<=acc; pc<=pc+1; stay in FETCH. The write is visible on the memory ports for exactly the next cycle.
  - 3 JMP: dm_raddr<=a; pc is not incremented; go to EXEC.
  - 8 JZ: if acc==0, behave as JMP. Otherwise pc<=pc+1, 1 cycle total.
  - 6 NEG: acc<=-acc (two's complement, mod 2^DW); pc<=pc+1.
  - 9 LDI: acc<=zero-extended a, truncated to DW if AW>DW; pc<=pc+1.
  - 15 HALT: done<=1; pc unchanged; go to HALT.
  - All other opcodes: NOP; pc<=pc+1.
- EXEC applies the operation to acc using dm_rdata, then returns to FETCH:
  - LOAD: acc<=dm_rdata.
  - ADD: acc<=acc+dm_rdata, mod 2^DW, carry discarded.
  - AND: acc<=acc&dm_rdata.
  - XOR: acc<=acc^dm_rdata.
  - POPCNT: acc<=number of 1 bits in dm_rdata, zero-extended.
  - JMP/JZ-taken: latch hi<=dm_rdata; dm_raddr<=a+1 (wraps mod 2^AW); go to JMP_LO.
- JMP_LO: pc <= {hi, dm_rdata}[PCW-1:0]; go to FETCH.
- Latency:
  - 1 cycle: NOP, NEG, LDI, STORE, JZ-not-taken.
  - 2 cycles: memory-read ALU ops.
  - 3 cycles: JMP and JZ-taken.
- The operand address a is held internally through EXEC and JMP_LO; im_data may change once pc moves.
- dm_we is high for exactly one cycle per STORE and low at all other times.
- A LOAD immediately after a STORE to the same address reads the new value. The memory is write-before-read by the following cycle; the core inserts no extra stall.
- pc increments wrap mod 2^PCW.
- HALT: state, pc and acc are frozen and done stays 1 until start. acc_out and done hold their values.

Test Plan:
- Reset check: start=1 for 2 cycles, then program [LDI 5, HALT] -> acc_out=5, done=1 on cycle 3 after start deasserts, pc frozen at 1.
- ALU path: mem[3]=0xF0, mem[4]=0x3C; program [LOAD 3, XOR 4, ADD 4, AND 3, POPCNT 3, HALT] -> acc sequence 0xF0, 0xCC, 0x08, 0x00, 0x04; done after 11 cycles.
- NEG and wrap: LDI 1, NEG -> acc=0xFF; ADD of mem=0x01 -> acc=0x00, carry dropped.
- STORE/LOAD back-to-back: LDI 0x2A, STORE 10, LOAD 10 -> dm_we pulses once with waddr=10 and wdata=0x2A; acc=0x2A.
- Jumps:
  - mem[20]=0x00, mem[21]=0x07; JMP 20 at pc=2 -> pc=7 after 3 cycles.
  - JZ with acc=0 -> taken.
  - JZ with acc=1 -> pc=pc+1 in 1 cycle.
  - JMP with a=127 reads the low byte from address 0.
- Mid-operation reset: assert start in the EXEC cycle of LOAD, and separately in the FETCH cycle of STORE -> acc=0, pc=0, no dm_we pulse, done=0.

Source files
------------

// File: rtl/acc_core_param.sv
// acc_core_param
//   Multi-cycle accumulator processor with parametrised widths. It fetches from
//   an external combinational instruction memory and runs load, ALU, store and
//   jump operations against an external data memory with a registered read
//   address. It also supports an immediate load, a conditional jump on zero, and
//   a halt instruction that raises done.
//
//   Ports
//     clk       in   rising-edge clock
//     start     in   synchronous active-high reset; restarts the program at 0
//     im_addr   out  instruction address (the pc)
//     im_data   in   instruction word {op[3:0], a[AW-1:0]}, valid same cycle
//     dm_raddr  out  registered data read address
//     dm_rdata  in   read data, valid the cycle after dm_raddr is registered
//     dm_we     out  one-cycle write strobe
//     dm_waddr  out  registered write address
//     dm_wdata  out  registered write data
//     acc_out   out  accumulator
//     done      out  high while halted
//
//   Parameter constraints: PCW <= 2*DW, IW == 4+AW.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_FETCH  | decode im_data; do 1-cycle ops or issue the operand read
//   S_EXEC   | apply dm_rdata to acc, or latch jump high byte and read a+1
//   S_JMP_LO | load pc from {hi, dm_rdata}
//   S_HALT   | frozen until start; done held high

module acc_core_param #(
    parameter int DW  = 8,
    parameter int AW  = 7,
    parameter int PCW = 16,
    parameter int IW  = 11
) (
    input  logic           clk,
    input  logic           start,
    output logic [PCW-1:0] im_addr,
    input  logic [IW-1:0]  im_data,
    output logic [AW-1:0]  dm_raddr,
    input  logic [DW-1:0]  dm_rdata,
    output logic           dm_we,
    output logic [AW-1:0]  dm_waddr,
    output logic [DW-1:0]  dm_wdata,
    output logic [DW-1:0]  acc_out,
    output logic           done
);

    localparam logic [3:0] OP_POPCNT = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_JMP    = 4'd3;
    localparam logic [3:0] OP_ADD    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_NEG    = 4'd6;
    localparam logic [3:0] OP_XOR    = 4'd7;
    localparam logic [3:0] OP_JZ     = 4'd8;
    localparam logic [3:0] OP_LDI    = 4'd9;
    localparam logic [3:0] OP_HALT   = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_JMP_LO = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic [AW-1:0]  raddr_q, raddr_d;
    logic           we_q, we_d;
    logic [AW-1:0]  waddr_q, waddr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           done_q, done_d;
    logic [3:0]     op_q, op_d;     // opcode carried into EXEC
    logic [AW-1:0]  a_q, a_d;       // operand kept once pc has moved on
    logic [DW-1:0]  hi_q, hi_d;     // jump target high byte

    logic [3:0]     op_w;
    logic [AW-1:0]  a_w;
    logic [DW-1:0]  pop_w;

    assign op_w = im_data[IW-1:IW-4];
    assign a_w  = im_data[AW-1:0];

    always_comb begin
        pop_w = '0;
        for (int i = 0; i < DW; i++) begin
            pop_w = pop_w + DW'(dm_rdata[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        raddr_d = raddr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        op_d    = op_q;
        a_d     = a_q;
        hi_d    = hi_q;

        case (state_q)
            S_FETCH: begin
                case (op_w)
                    OP_POPCNT, OP_LOAD, OP_ADD, OP_AND, OP_XOR: begin
                        raddr_d = a_w;
                        op_d    = op_w;
                        a_d     = a_w;
                        pc_d    = pc_q + PCW'(1);
                        state_d = S_EXEC;
                    end
                    OP_STORE: begin
                        we_d    = 1'b1;
                        waddr_d = a_w;
                        wdata_d = acc_q;
                        pc_d    = pc_q + PCW'(1);
                    end
                    OP_JMP: begin
                        raddr_d = a_w;
                        op_d    = op_w;
                        a_d     = a_w;
                        state_d = S_EXEC;
                    end
                    OP_JZ: begin
                        if (acc_q == '0) begin
                            raddr_d = a_w;
                            op_d    = op_w;
                            a_d     = a_w;
                            state_d = S_EXEC;
                        end else begin
                            pc_d = pc_q + PCW'(1);
                        end
                    end
                    OP_NEG: begin
                        acc_d = -acc_q;
                        pc_d  = pc_q + PCW'(1);
                    end
                    OP_LDI: begin
                        // size cast zero-extends or truncates as AW vs DW requires
                        acc_d = DW'(a_w);
                        pc_d  = pc_q + PCW'(1);
                    end
                    OP_HALT: begin
                        done_d  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        pc_d = pc_q + PCW'(1);
                    end
                endcase
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_LOAD:   acc_d = dm_rdata;
                    OP_ADD:    acc_d = acc_q + dm_rdata;
                    OP_AND:    acc_d = acc_q & dm_rdata;
                    OP_XOR:    acc_d = acc_q ^ dm_rdata;
                    OP_POPCNT: acc_d = pop_w;
                    OP_JMP, OP_JZ: begin
                        hi_d    = dm_rdata;
                        raddr_d = a_q + AW'(1);
                        state_d = S_JMP_LO;
                    end
                    default: ;
                endcase
            end

            S_JMP_LO: begin
                pc_d    = PCW'({hi_q, dm_rdata});
                state_d = S_FETCH;
            end

            S_HALT: ;

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            raddr_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            raddr_q <= raddr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            op_q    <= op_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
        end
    end

    assign im_addr  = pc_q;
    assign dm_raddr = raddr_q;
    assign dm_we    = we_q;
    assign dm_waddr = waddr_q;
    assign dm_wdata = wdata_q;
    assign acc_out  = acc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_acc_core_param.sv
// tb_acc_core_param
//   Directed program tests for acc_core_param with default parameters. The bench
//   models instruction memory as a combinational array and data memory with
//   combinational read and posedge write. Inputs are driven and outputs sampled
//   on the falling edge.

module tb_acc_core_param;

    localparam int DW  = 8;
    localparam int AW  = 7;
    localparam int PCW = 16;
    localparam int IW  = 11;

    logic           clk = 1'b0;
    logic           start;
    logic [PCW-1:0] im_addr;
    logic [IW-1:0]  im_data;
    logic [AW-1:0]  dm_raddr;
    logic [DW-1:0]  dm_rdata;
    logic           dm_we;
    logic [AW-1:0]  dm_waddr;
    logic [DW-1:0]  dm_wdata;
    logic [DW-1:0]  acc_out;
    logic           done;

    logic [IW-1:0]  im [65536];
    logic [DW-1:0]  dm [128];
    int             we_cnt = 0;
    int             we_base;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    acc_core_param #(.DW(DW), .AW(AW), .PCW(PCW), .IW(IW)) dut (
        .clk      (clk),
        .start    (start),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .dm_raddr (dm_raddr),
        .dm_rdata (dm_rdata),
        .dm_we    (dm_we),
        .dm_waddr (dm_waddr),
        .dm_wdata (dm_wdata),
        .acc_out  (acc_out),
        .done     (done)
    );

    assign im_data  = im[im_addr];
    assign dm_rdata = dm[dm_raddr];

    always @(posedge clk) begin
        if (dm_we) begin
            dm[dm_waddr] <= dm_wdata;
            we_cnt       <= we_cnt + 1;
        end
    end

    function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_im;
        for (int i = 0; i < 512; i++) im[i] = ins(4'd15, '0);
    endtask

    // two rising edges with start high, then release on a falling edge
    task automatic restart;
        start = 1'b1;
        step(2);
        start = 1'b0;
    endtask

    initial begin
        start = 1'b1;
        for (int i = 0; i < 128; i++) dm[i] = '0;
        clear_im();

        // reset state, LDI then HALT freeze
        im[0] = ins(4'd9, 7'd5);
        im[1] = ins(4'd15, 7'd0);
        step(2);
        chk("rst_acc",    acc_out,  0);
        chk("rst_pc",     im_addr,  0);
        chk("rst_done",   done,     0);
        chk("rst_we",     dm_we,    0);
        chk("rst_raddr",  dm_raddr, 0);
        chk("rst_waddr",  dm_waddr, 0);
        chk("rst_wdata",  dm_wdata, 0);
        start = 1'b0;
        step(1);
        chk("ldi_acc",    acc_out, 8'h05);
        chk("ldi_pc",     im_addr, 1);
        chk("ldi_done",   done,    0);
        step(1);
        chk("halt_done",  done,    1);
        step(3);
        chk("halt_done_hold", done,    1);
        chk("halt_pc_hold",   im_addr, 1);
        chk("halt_acc_hold",  acc_out, 8'h05);

        // ALU path
        clear_im();
        dm[3] = 8'hF0;
        dm[4] = 8'h3C;
        im[0] = ins(4'd1, 7'd3);
        im[1] = ins(4'd7, 7'd4);
        im[2] = ins(4'd4, 7'd4);
        im[3] = ins(4'd5, 7'd3);
        im[4] = ins(4'd0, 7'd3);
        im[5] = ins(4'd15, 7'd0);
        restart();
        chk("alu_done_cleared", done, 0);
        step(2); chk("alu_load",   acc_out, 8'hF0);
        step(2); chk("alu_xor",    acc_out, 8'hCC);
        step(2); chk("alu_add",    acc_out, 8'h08);
        step(2); chk("alu_and",    acc_out, 8'h00);
        step(2); chk("alu_popcnt", acc_out, 8'h04);
        chk("alu_done_c10", done, 0);
        step(1); chk("alu_done_c11", done, 1);

        // NEG and ADD wrap
        clear_im();
        dm[5] = 8'h01;
        im[0] = ins(4'd9, 7'd1);
        im[1] = ins(4'd6, 7'd0);
        im[2] = ins(4'd4, 7'd5);
        im[3] = ins(4'd15, 7'd0);
        restart();
        step(1); chk("neg_ldi",  acc_out, 8'h01);
        step(1); chk("neg_acc",  acc_out, 8'hFF);
        step(2); chk("add_wrap", acc_out, 8'h00);
        step(1); chk("neg_done", done, 1);

        // STORE then LOAD of the same address
        clear_im();
        dm[10] = 8'h00;
        im[0] = ins(4'd9, 7'h2A);
        im[1] = ins(4'd2, 7'd10);
        im[2] = ins(4'd9, 7'd0);
        im[3] = ins(4'd1, 7'd10);
        im[4] = ins(4'd15, 7'd0);
        restart();
        we_base = we_cnt;
        step(1);
        chk("st_acc",      acc_out, 8'h2A);
        chk("st_we_pre",   dm_we,   0);
        step(1);
        chk("st_we",       dm_we,    1);
        chk("st_waddr",    dm_waddr, 10);
        chk("st_wdata",    dm_wdata, 8'h2A);
        step(1);
        chk("st_we_post",  dm_we,   0);
        chk("st_ldi0",     acc_out, 8'h00);
        step(2);
        chk("st_loadback", acc_out, 8'h2A);
        chk("st_mem",      dm[10],  8'h2A);
        chk("st_we_count", we_cnt - we_base, 1);

        // jumps
        clear_im();
        dm[20]  = 8'h00; dm[21] = 8'h07;
        dm[22]  = 8'h01; dm[23] = 8'h0C;
        dm[127] = 8'h00; dm[0]  = 8'h10;
        im[0]      = ins(4'd10, 7'd0);
        im[1]      = ins(4'd10, 7'd0);
        im[2]      = ins(4'd3, 7'd20);
        im[7]      = ins(4'd9, 7'd1);
        im[8]      = ins(4'd8, 7'd22);
        im[9]      = ins(4'd9, 7'd0);
        im[10]     = ins(4'd8, 7'd22);
        im[16'h10C] = ins(4'd3, 7'd127);
        im[16'h010] = ins(4'd15, 7'd0);
        restart();
        step(2);  chk("jmp_pc_c2",   im_addr, 2);
        step(2);  chk("jmp_pc_c4",   im_addr, 2);
        step(1);  chk("jmp_pc_c5",   im_addr, 7);
        step(1);  chk("jz_ldi1",     acc_out, 8'h01);
        step(1);  chk("jz_nt_pc",    im_addr, 9);
        step(1);  chk("jz_ldi0",     acc_out, 8'h00);
        step(2);  chk("jz_t_pc_c10", im_addr, 10);
        step(1);  chk("jz_t_pc_c11", im_addr, 16'h010C);
        step(2);
        chk("jmp127_pc_c13",    im_addr,  16'h010C);
        chk("jmp127_raddr_wrap", dm_raddr, 0);
        step(1);  chk("jmp127_pc",   im_addr, 16'h0010);
        step(1);  chk("jmp_done",    done, 1);

        // reset during LOAD execute
        clear_im();
        dm[3] = 8'hF0;
        im[0] = ins(4'd1, 7'd3);
        im[1] = ins(4'd15, 7'd0);
        restart();
        chk("mid1_done_cleared", done, 0);
        step(1);
        start = 1'b1;
        step(1);
        chk("mid1_acc",  acc_out, 0);
        chk("mid1_pc",   im_addr, 0);
        chk("mid1_done", done,    0);

        // reset during STORE decode
        clear_im();
        dm[11] = 8'h55;
        im[0] = ins(4'd9, 7'h33);
        im[1] = ins(4'd2, 7'd11);
        im[2] = ins(4'd15, 7'd0);
        restart();
        step(1);
        chk("mid2_ldi", acc_out, 8'h33);
        we_base = we_cnt;
        start = 1'b1;
        step(1);
        chk("mid2_we",   dm_we,   0);
        chk("mid2_acc",  acc_out, 0);
        chk("mid2_pc",   im_addr, 0);
        chk("mid2_done", done,    0);
        step(1);
        chk("mid2_we_count", we_cnt - we_base, 0);
        chk("mid2_mem",      dm[11], 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
